// File: rtl/iq_demod_pkg.sv
// Shared widths and helpers for the I/Q demodulator.
// Optional build macro IQ_DEMOD_SAT_EN: when defined, sat_trunc clamps
// out-of-range results to the signed output limits; when undefined it
// passes the value through so the caller keeps the low bits (wrap).
package iq_demod_pkg;

  localparam int DEF_IN_W  = 24;
  localparam int DEF_CAR_W = 24;
  localparam int DEF_DECIM = 10;
  localparam int DEF_OUT_W = 24;
  localparam int DEF_SHIFT = 24;

  // Working width for the range helpers; must exceed any ACC_W in use.
  localparam int WIDE_W = 128;

  // Accumulator width that can hold DECIM full-precision products without wrapping.
  function automatic int acc_width(input int in_w, input int car_w, input int decim);
    return in_w + car_w + $clog2(decim);
  endfunction

  // True when x does not fit in an out_w-bit signed field.
  function automatic logic out_of_range(input logic signed [WIDE_W-1:0] x, input int out_w);
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] maxv;
    logic signed [WIDE_W-1:0] minv;
    one  = {{(WIDE_W-1){1'b0}}, 1'b1};
    maxv = (one <<< (out_w - 1)) - one;
    minv = -(one <<< (out_w - 1));
    return (x > maxv) || (x < minv);
  endfunction

  // Clamp (or pass through for wrap) before the caller narrows to out_w bits.
  function automatic logic signed [WIDE_W-1:0] sat_trunc(input logic signed [WIDE_W-1:0] x,
                                                         input int out_w);
`ifdef IQ_DEMOD_SAT_EN
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] maxv;
    logic signed [WIDE_W-1:0] minv;
    one  = {{(WIDE_W-1){1'b0}}, 1'b1};
    maxv = (one <<< (out_w - 1)) - one;
    minv = -(one <<< (out_w - 1));
    if (x > maxv)      return maxv;
    else if (x < minv) return minv;
    else               return x;
`else
    if (out_w < 1) return '0;
    return x;
`endif
  endfunction

endpackage

// File: rtl/iq_demod_lpf_integrate_dump.sv
// Integrate-and-dump accumulator with output scaling for one rail (I or Q).
// Saturation versus wrap of the scaled result follows IQ_DEMOD_SAT_EN.
module iq_integrate_dump
  import iq_demod_pkg::*;
#(
  parameter int PROD_W = 48,
  parameter int ACC_W  = 52,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vld_i,
  input  logic                     sop_i,
  input  logic                     dump_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [OUT_W-1:0]  data_o,
  output logic                     ovf_o
);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum_p2;
  logic signed [ACC_W-1:0]  shifted_p2;
  logic signed [WIDE_W-1:0] shifted_wide_p2;
  logic signed [OUT_W-1:0]  data_q, data_d;
  logic                     ovf_q, ovf_d;

  assign prod_ext        = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign sum_p2          = acc_q + prod_ext;
  assign shifted_p2      = sum_p2 >>> SHIFT;
  assign shifted_wide_p2 = {{(WIDE_W-ACC_W){shifted_p2[ACC_W-1]}}, shifted_p2};

  // Next-state: restart, dump (scale and flag overflow), or accumulate.
  always_comb begin
    acc_d  = acc_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (vld_i) begin
      if (sop_i) begin
        acc_d = prod_ext;
      end else if (dump_i) begin
        acc_d  = '0;
        data_d = OUT_W'(sat_trunc(shifted_wide_p2, OUT_W));
        if (out_of_range(shifted_wide_p2, OUT_W)) ovf_d = 1'b1;
      end else begin
        acc_d = sum_p2;
      end
    end
  end

  // ---- stage 2: accumulator, held output and sticky overflow ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_o = data_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/iq_demod_lpf.sv
// Coherent I/Q demodulator: mixes the received sample with local I/Q
// carriers and integrate-and-dumps over DECIM strobes.
// Build macro IQ_DEMOD_SAT_EN selects saturating (defined) or wrapping output.
module iq_demod_lpf
  import iq_demod_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int CAR_W = DEF_CAR_W,
  parameter int DECIM = DEF_DECIM,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_en,
  input  logic                    sym_start,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic signed [CAR_W-1:0] i_car,
  input  logic signed [CAR_W-1:0] q_car,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    out_valid,
  output logic                    overflow
);

  localparam int ACC_W  = acc_width(IN_W, CAR_W, DECIM);
  localparam int PROD_W = IN_W + CAR_W;
  localparam int CNT_W  = $clog2(DECIM);

  logic signed [PROD_W-1:0] y_ext, i_ext, q_ext;
  logic signed [PROD_W-1:0] prod_i_p1_q, prod_q_p1_q;
  logic                     vld_p1_q, sop_p1_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     dump_p1;
  logic                     out_valid_q, out_valid_d;
  logic                     ovf_i, ovf_q;

  assign y_ext = {{CAR_W{y_in[IN_W-1]}}, y_in};
  assign i_ext = {{IN_W{i_car[CAR_W-1]}}, i_car};
  assign q_ext = {{IN_W{q_car[CAR_W-1]}}, q_car};

  // ---- stage 1: full-precision mixer products, captured on each strobe ----
  always_ff @(posedge clk) begin
    if (sample_en) begin
      prod_i_p1_q <= y_ext * i_ext;
      prod_q_p1_q <= y_ext * q_ext;
    end
  end

  // Stage-1 strobe and window-start flags travel with the products.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      sop_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= sample_en;
      sop_p1_q <= sample_en & sym_start;
    end
  end

  assign dump_p1 = (cnt_q == CNT_W'(DECIM - 1));

  // Window counter and dump strobe; a restart beats a dump on the same sample.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    if (vld_p1_q) begin
      if (sop_p1_q) begin
        cnt_d = CNT_W'(1);
      end else if (dump_p1) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---- stage 2: shared window counter and output strobe ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  iq_integrate_dump #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_int_i (
    .clk     (clk),
    .reset_n (reset_n),
    .vld_i   (vld_p1_q),
    .sop_i   (sop_p1_q),
    .dump_i  (dump_p1),
    .prod_i  (prod_i_p1_q),
    .data_o  (i_out),
    .ovf_o   (ovf_i)
  );

  iq_integrate_dump #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_int_q (
    .clk     (clk),
    .reset_n (reset_n),
    .vld_i   (vld_p1_q),
    .sop_i   (sop_p1_q),
    .dump_i  (dump_p1),
    .prod_i  (prod_q_p1_q),
    .data_o  (q_out),
    .ovf_o   (ovf_q)
  );

  assign out_valid = out_valid_q;
  assign overflow  = ovf_i | ovf_q;

endmodule

// File: tb/tb_iq_demod_lpf.sv
// Bench for iq_demod_lpf: DECIM=4/SHIFT=0 instance checked every cycle
// against a window-sum model, plus a default-parameter instance for the
// quadrature-carrier case.
module tb_iq_demod_lpf;
  localparam int DECIM = 4;
  localparam int SHIFT = 0;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic sample_en = 1'b0, sym_start = 1'b0;
  logic signed [23:0] y_in = '0, i_car = '0, q_car = '0;
  logic signed [23:0] i_out, q_out;
  logic out_valid, overflow;

  logic en2 = 1'b0, sym2 = 1'b0;
  logic signed [23:0] y2 = '0, ic2 = '0, qc2 = '0;
  logic signed [23:0] i2, q2;
  logic v2, ov2;

  iq_demod_lpf #(.IN_W(24), .CAR_W(24), .DECIM(DECIM), .OUT_W(24), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .sym_start(sym_start),
    .y_in(y_in), .i_car(i_car), .q_car(q_car),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .overflow(overflow));

  iq_demod_lpf dut2 (
    .clk(clk), .reset_n(reset_n), .sample_en(en2), .sym_start(sym2),
    .y_in(y2), .i_car(ic2), .q_car(qc2),
    .i_out(i2), .q_out(q2), .out_valid(v2), .overflow(ov2));

  int passes = 0, total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; longint iv; longint qv; bit ovf; } exp_t;
  exp_t expq[$];
  int cyc = 0;
  longint wi = 0, wq = 0;
  int wcnt = 0;
  longint exp_i = 0, exp_q = 0;
  bit exp_ovf = 1'b0;
  int nvalid = 0;

  function automatic longint reduce(input longint v);
    longint s;
    s = v >>> SHIFT;
`ifdef IQ_DEMOD_SAT_EN
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
`else
    return (s <<< 40) >>> 40;
`endif
  endfunction

  function automatic bit oor(input longint v);
    longint s;
    s = v >>> SHIFT;
    return (s > MAXV) || (s < MINV);
  endfunction

  // Window sums per strobe; result becomes visible one edge after the sample edge after that.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        wi = 0; wq = 0; wcnt = 0;
        expq.delete();
        exp_i = 0; exp_q = 0; exp_ovf = 1'b0;
      end else if (sample_en) begin
        longint pi, pqv;
        pi  = longint'(y_in) * longint'(i_car);
        pqv = longint'(y_in) * longint'(q_car);
        if (sym_start) begin
          wi = pi; wq = pqv; wcnt = 1;
        end else begin
          wi += pi; wq += pqv; wcnt++;
          if (wcnt == DECIM) begin
            exp_t e;
            e.due = cyc + 1;
            e.iv  = reduce(wi);
            e.qv  = reduce(wq);
            e.ovf = oor(wi) || oor(wq);
            expq.push_back(e);
            wi = 0; wq = 0; wcnt = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        bit ev;
        ev = (expq.size() > 0) && (expq[0].due == cyc);
        if (ev) begin
          exp_i = expq[0].iv;
          exp_q = expq[0].qv;
          exp_ovf = exp_ovf | expq[0].ovf;
          void'(expq.pop_front());
        end
        chk("out_valid", longint'(out_valid), longint'(ev));
        chk("i_out", longint'(i_out), exp_i);
        chk("q_out", longint'(q_out), exp_q);
        chk("overflow", longint'(overflow), longint'(exp_ovf));
        if (out_valid) nvalid++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit en, input bit sym, input int y, input int ic, input int qc);
    @(negedge clk);
    sample_en = en;
    sym_start = sym;
    y_in  = y[23:0];
    i_car = ic[23:0];
    q_car = qc[23:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic window4(input int y, input int ic, input int qc, input bit first_sym, input int gap);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k == 0) && first_sym, y, ic, qc);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic nvalid_now(output int n);
    #2 n = nvalid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0, nv1;
    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_i_out", longint'(i_out), 0);
    chk("rst_q_out", longint'(q_out), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_overflow", longint'(overflow), 0);

    // Constant input, back-to-back, latency pinned
    window4(100, 2, -3, 1'b1, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    chk("lat_early_valid", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", longint'(out_valid), 1);
    chk("const_i", longint'(i_out), 800);
    chk("const_q", longint'(q_out), -1200);
    chk("const_ovf", longint'(overflow), 0);
    idle(3);

    // Mixed values, including carrier extremes
    drive(1'b1, 1'b1, 1000, -7, 5);
    drive(1'b1, 1'b0, -2000, 300, -11);
    drive(1'b1, 1'b0, 3, 8388607, -8388608);
    drive(1'b1, 1'b0, 77, -1, 1);
    idle(4);

    // Gapped strobes must match back-to-back
    nvalid_now(nv0);
    window4(100, 2, -3, 1'b1, 1041);
    nvalid_now(nv1);
    chk("gap_count", nv1 - nv0, 1);
    chk("gap_i", longint'(i_out), 800);
    chk("gap_q", longint'(q_out), -1200);
    nvalid_now(nv0);
    window4(100, 2, -3, 1'b1, 0);
    window4(100, 2, -3, 1'b1, 0);
    idle(4);
    nvalid_now(nv1);
    chk("b2b_count", nv1 - nv0, 2);

    // Restart on 3rd strobe; sym_start without sample_en ignored
    nvalid_now(nv0);
    drive(1'b1, 1'b1, 1, 1000, -1000);
    drive(1'b1, 1'b0, 1, 1000, -1000);
    drive(1'b1, 1'b1, 1, 10, 1);
    idle(3);
    nvalid_now(nv1);
    chk("abort_no_out", nv1 - nv0, 0);
    drive(1'b1, 1'b0, 1, 20, 2);
    drive(1'b0, 1'b1, 999, 999, 999);
    drive(1'b1, 1'b0, 1, 30, 3);
    drive(1'b1, 1'b0, 1, 40, 4);
    idle(4);
    nvalid_now(nv1);
    chk("restart_count", nv1 - nv0, 1);
    chk("restart_i", longint'(i_out), 100);
    chk("restart_q", longint'(q_out), 10);

    // Restart on what would be the dump sample
    nvalid_now(nv0);
    drive(1'b1, 1'b1, 1, 5, 5);
    drive(1'b1, 1'b0, 1, 5, 5);
    drive(1'b1, 1'b0, 1, 5, 5);
    drive(1'b1, 1'b1, 1, 1, 1);
    idle(3);
    nvalid_now(nv1);
    chk("dump_restart_no_out", nv1 - nv0, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1, 1, 1);
    idle(4);
    chk("dump_restart_i", longint'(i_out), 4);
    chk("dump_restart_q", longint'(q_out), 4);

    // Reset mid-window, then a window without sym_start
    drive(1'b1, 1'b1, 1000, 1000, 1000);
    drive(1'b1, 1'b0, 1000, 1000, 1000);
    @(negedge clk);
    sample_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_i", longint'(i_out), 0);
    chk("midrst_q", longint'(q_out), 0);
    chk("midrst_valid", longint'(out_valid), 0);
    window4(100, 2, -3, 1'b0, 0);
    idle(4);
    chk("postrst_i", longint'(i_out), 800);
    chk("postrst_q", longint'(q_out), -1200);

    // Overflow
    window4(8388607, 8388607, 0, 1'b1, 0);
    idle(4);
`ifdef IQ_DEMOD_SAT_EN
    chk("ovf_i", longint'(i_out), 8388607);
`else
    chk("ovf_i", longint'(i_out), 4);
`endif
    chk("ovf_flag", longint'(overflow), 1);
    window4(100, 2, -3, 1'b1, 0);
    idle(4);
    chk("ovf_sticky", longint'(overflow), 1);
    chk("ovf_after_i", longint'(i_out), 800);

    // Default parameters, quadrature carriers, y = i carrier
    begin
      int ic[10], qc[10];
      longint si, sq;
      bit got;
      real a, ph;
      a = 4194304.0;
      si = 0; sq = 0;
      for (int k = 0; k < 10; k++) begin
        ph = 2.0 * 3.14159265358979 * k / 10.0;
        ic[k] = $rtoi($floor(a * $cos(ph) + 0.5));
        qc[k] = $rtoi($floor(a * $sin(ph) + 0.5));
        si += longint'(ic[k]) * longint'(ic[k]);
        sq += longint'(ic[k]) * longint'(qc[k]);
      end
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        en2 = 1'b1; sym2 = (k == 0);
        y2 = ic[k][23:0]; ic2 = ic[k][23:0]; qc2 = qc[k][23:0];
      end
      @(negedge clk);
      en2 = 1'b0; sym2 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (v2) begin got = 1'b1; break; end
      end
      chk("quad_valid_seen", longint'(got), 1);
      chk("quad_i", longint'(i2), si >>> 24);
      chk("quad_q", longint'(q2), sq >>> 24);
      chk("quad_q_small", longint'((q2 <= 2) && (q2 >= -2)), 1);
      chk("quad_i_positive", longint'(i2 > 0), 1);
      chk("quad_ovf", longint'(ov2), 0);
    end

    idle(2);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/iq_demod_lpf.md
# iq_demod_lpf

Coherent I/Q demodulator stage that sits directly downstream of the I/Q modulator/NCO block. On each sample strobe it multiplies the received sample by the local I and Q carriers, then integrates the products over a fixed window of `DECIM` strobes (integrate-and-dump low-pass filter). It emits one scaled baseband I/Q pair per window and provides window alignment and overflow reporting.

## Interface
Parameters:
- `IN_W`, 24: width of the received sample `y_in`, signed.
- `CAR_W`, 24: width of the carrier inputs, signed.
- `DECIM`, 10: strobes per integration window; legal range 2..1024.
- `OUT_W`, 24: width of the baseband outputs, signed.
- `SHIFT`, 24: arithmetic right shift applied to the accumulator before output.
- Local parameter `ACC_W` = `IN_W + CAR_W + $clog2(DECIM)`.

Ports (clock and reset: reset `reset_n`, synchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `reset_n` in 1: synchronous active-low reset.
- `sample_en` in 1: one-cycle strobe marking a valid `y_in`/carrier set; may be high on consecutive cycles.
- `sym_start` in 1: qualified by `sample_en`; that sample opens a new window.
- `y_in` in `IN_W`: received sample, two's complement.
- `i_car` in `CAR_W`: in-phase carrier sample, two's complement.
- `q_car` in `CAR_W`: quadrature carrier sample, two's complement.
- `i_out` out `OUT_W`: baseband I result; held between windows.
- `q_out` out `OUT_W`: baseband Q result; held between windows.
- `out_valid` out 1: one-cycle pulse when `i_out`/`q_out` update.
- `overflow` out 1: sticky; set when an output is clipped or wrapped; cleared only by reset.

## Operation
- **Stage 1 (multiply):** when `sample_en` is high, register `p_i = y_in * i_car` and `p_q = y_in * q_car`. Products are full-precision `IN_W+CAR_W` signed. Stage 1 also registers `v1 <= sample_en` and `s1 <= sample_en & sym_start`.
- **Stage 2 (integrate/dump):** window counter `cnt`, 0..`DECIM-1`. When `v1` is high:
  - If `s1` is high: `acc <= sext(p)` and `cnt <= 1`. The partial window is discarded and produces no output.
  - Else if `cnt == DECIM-1` (dump):
    - `i_out`/`q_out <= scale(acc + sext(p))`.
    - `out_valid <= 1`.
    - `acc <= 0`.
    - `cnt <= 0`.
  - Else: `acc <= acc + sext(p)` and `cnt <= cnt + 1`.
- When `v1` is low, `acc` and `cnt` hold.
- `scale(x)`: `x >>> SHIFT`, reduced to `OUT_W` bits per the Configuration section. `overflow` is set on any dump whose shifted value lies outside the `OUT_W` signed range.
- `ACC_W` sizing guarantees the accumulator itself never wraps.
- I and Q paths are identical and share `cnt`.

## Timing
- Reset values: `i_out = 0`, `q_out = 0`, `out_valid = 0`, `overflow = 0`, `acc = 0`, `cnt = 0`, `v1 = 0`, `s1 = 0`.
- Latency: the last strobe of a window at cycle N produces `out_valid` high in cycle N+2.
- Throughput: one sample per cycle. Back-to-back strobes need no stall.
- `out_valid` is high for exactly one cycle per completed window.
- `sym_start` without `sample_en` is ignored.
- Reset asserted mid-window discards the pipeline and accumulator; no `out_valid` is produced for that window.
- `sym_start` on the sample that would have been the dump sample: restart wins, and no output is produced.

## Configuration
- Macro `IQ_DEMOD_SAT_EN`:
  - Defined: out-of-range shifted results saturate to `2^(OUT_W-1)-1` or `-2^(OUT_W-1)`.
  - Undefined: the low `OUT_W` bits of the shifted result are output (wrap).
  - `overflow` is set in both builds.

## Structure
- Package `iq_demod_pkg`: default widths, the `ACC_W` computation function, and the `sat_trunc` function (guarded by `IQ_DEMOD_SAT_EN`).
- Sub-module `iq_integrate_dump`: one accumulator plus scale/saturate path, instantiated twice (I, Q). Each instance is fed `v1`, `s1` and the shared `cnt` dump flag.
- Top level owns the multipliers, stage-1 registers and window counter.

## Test plan
- Constant input, `DECIM=4`, `SHIFT=0`: `y_in=100`, `i_car=2`, `q_car=-3` on 4 strobes → `i_out=800`, `q_out=-1200`, `out_valid` 2 cycles after the 4th strobe, `overflow=0`.
- Gapped strobes (one every 1041 cycles) and back-to-back strobes give identical results; exactly one `out_valid` per 4 strobes.
- Overflow, `DECIM=4`, `SHIFT=0`, `y_in = i_car = 0x7FFFFF`:
  - With `IQ_DEMOD_SAT_EN`: `i_out = 0x7FFFFF`.
  - Without it: `i_out = 4`.
  - Both builds: `overflow=1` and it stays set.
- `sym_start` with the 3rd strobe of a window (`DECIM=4`) → no output for the aborted window; the next output arrives after 4 strobes counted from the restart.
- `reset_n` low for one cycle after 2 strobes → all outputs 0; the next full window yields the correct sum with no stale contribution.
- Default parameters, quadrature sine carriers, `y_in = i_car` → `q_out` ≈ 0 (|q| ≤ 2 LSB), `i_out` positive.
